muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit downstream of the register file:

---
 rtl/rv32m_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// ---------------------------------------------------------------------------
// rv32m_pkg
// Shared RV32M definitions: funct3 encodings (also used by the decode unit),
// the multiply/divide FSM state type and the default datapath width.
// ---------------------------------------------------------------------------
package rv32m_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. One bit per cycle (XLEN CALC cycles)
// on operand magnitudes, with sign fix-up on the final cycle. Divide by zero
// and signed overflow are resolved without iterating.
//
// Ports
//   clk      : clock
//   reset    : synchronous, active-high; aborts any operation in flight
//   start    : launch an operation (sampled only in IDLE)
//   funct3   : RV32M operation select
//   rs1_data : operand A (multiplicand / dividend)
//   rs2_data : operand B (multiplier / divisor)
//   rd_in    : destination tag, captured with start
//   busy     : high while iterating
//   done     : one-cycle pulse, result/rd_out valid
//   result   : write-back data, held until the next completion
//   rd_out   : destination tag belonging to result
// ---------------------------------------------------------------------------
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                aneg_q, aneg_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  // Final sign correction and result selection from the accumulator.
  function automatic logic [XLEN-1:0] fixup(input logic [2:0]        op,
                                            input logic [2*XLEN-1:0] acc,
                                            input logic              neg,
                                            input logic              aneg);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg ? -acc : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    case (op)
      F3_MUL:  return prod[XLEN-1:0];
      F3_DIV:  return neg ? -quo : quo;
      F3_DIVU: return quo;
      F3_REM:  return aneg ? -rem : rem;
      F3_REMU: return rem;
      default: return prod[2*XLEN-1:XLEN];
    endcase
  endfunction

  // Operand decode at start. MUL ignores signs: the low half is sign-agnostic.
  logic            a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
            (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg = a_sgn & rs1_data[XLEN-1];
    b_neg = b_sgn & rs2_data[XLEN-1];
    div0  = funct3[2] && (rs2_data == '0);
    ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
            (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    if (div0)
      special_res = funct3[1] ? rs1_data : '1;
    else
      special_res = funct3[1] ? '0 : rs1_data;
  end

  // One iteration: shift-add multiply or restoring divide on the shared
  // accumulator {hi, lo}.
  logic [XLEN:0]     msum, dtrial;
  logic [2*XLEN-1:0] step;

  always_comb begin
    msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    dtrial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (!op_q[2])
      step = {msum, acc_q[XLEN-1:1]};
    else if (dtrial[XLEN])
      step = {acc_q[2*XLEN-2:0], 1'b0};
    else
      step = {dtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    aneg_d   = aneg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = funct3;
          rd_d   = rd_in;
          neg_d  = a_neg ^ b_neg;
          aneg_d = a_neg;
          cnt_d  = '0;
          if (div0 || ovf) begin
            result_d = special_res;
            rd_out_d = rd_in;
            state_d  = DONE;
          end else if (funct3[2]) begin
            acc_d   = {{XLEN{1'b0}}, mag(rs1_data, a_neg)};
            opb_d   = mag(rs2_data, b_neg);
            state_d = CALC;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag(rs2_data, b_neg)};
            opb_d   = mag(rs1_data, a_neg);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = fixup(op_q, step, neg_q, aneg_q);
          rd_out_d = rd_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    opb_q  <= opb_d;
    op_q   <= op_d;
    neg_q  <= neg_d;
    aneg_q <= aneg_d;
    rd_q   <= rd_d;
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit: each issued operation pushes its expected
// result, tag, completion cycle and busy-cycle count; a monitor pops and
// compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
  import rv32m_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [4:0]      rd_in = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    int              cyc;
    int              nbusy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ndone = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every completion against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        ndone++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", 64'(result), 64'(mon_e.res));
          check("rd_out", 64'(rd_out), 64'(mon_e.rd));
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(mon_e.nbusy));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge while the DUT is in IDLE; returns one negedge later.
  task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] rd,
                       input logic [XLEN-1:0] res, input bit special);
    exp_t e;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    e.res    = res;
    e.rd     = rd;
    e.cyc    = cyc + 1 + (special ? 0 : XLEN);
    e.nbusy  = special ? 0 : XLEN;
    exp_q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    funct3   = ~f3;
    rs1_data = ~a;
    rs2_data = a;
    rd_in    = ~rd;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [2:0] f3, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b, input logic [4:0] rd,
                     input logic [XLEN-1:0] res, input bit special);
    issue(f3, a, b, rd, res, special);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int snap;
  bit seen;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_rd_out", 64'(rd_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Multiply
    run(F3_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 1'b0);
    run(F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 1'b0);
    run(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 1'b0);
    run(F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 1'b0);
    run(F3_MULH,   32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 1'b0);
    run(F3_MUL,    32'h12345678, 32'h00000010, 5'd8, 32'h23456780, 1'b0);

    // Divide
    run(F3_DIV,  32'hFFFFFFEC, 32'd3,        5'd10, 32'hFFFFFFFA, 1'b0);
    run(F3_REM,  32'hFFFFFFEC, 32'd3,        5'd11, 32'hFFFFFFFE, 1'b0);
    run(F3_DIVU, 32'd100,      32'd7,        5'd12, 32'd14,       1'b0);
    run(F3_REMU, 32'd100,      32'd7,        5'd13, 32'd2,        1'b0);
    run(F3_DIV,  32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 1'b0);
    run(F3_REM,  32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        1'b0);

    // Special cases: no iteration
    run(F3_DIVU, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1'b1);
    run(F3_REM,  32'd5,        32'd0,        5'd17, 32'd5,        1'b1);
    run(F3_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1'b1);
    run(F3_REM,  32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1'b1);

    // start during CALC and DONE ignored; start in the following IDLE taken
    issue(F3_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
    repeat (4) @(negedge clk);
    funct3 = F3_MUL; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("wait_done", 64'(seen), 64'd1);
    funct3 = F3_MUL; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    issue(F3_REMU, 32'd100, 32'd7, 5'd3, 32'd2, 1'b0);
    drain();
    check("result_hold", 64'(result), 64'd2);
    check("rd_out_hold", 64'(rd_out), 64'd3);

    // Reset in CALC cycle 10 aborts without a done pulse
    issue(F3_MUL, 32'd5, 32'd6, 5'd7, 32'd30, 1'b0);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    exp_q.delete(exp_q.size() - 1);
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_rd_out", 64'(rd_out), 64'd0);
    reset = 1'b0;
    snap = ndone;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(ndone), 64'(snap));

    // Normal operation after abort
    run(F3_MULHU, 32'h80000000, 32'h00000004, 5'd21, 32'h00000002, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
